// File: rtl/mem_stage.sv
// Memory-access stage: unpacks EX/MEM, runs the data-memory handshake, resolves branches, registers MEM/WB.
// Optional wait-cycle timeout with sticky memError is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int N       = 24,
  parameter int BW      = 16 + 2*N,
  parameter int WBW     = 5 + N,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           flush,
  input  logic [BW-1:0]  bufferIn,
  output logic           memReq,
  output logic           memWe,
  output logic [N-1:0]   memAddr,
  output logic [N-1:0]   memWData,
  input  logic           memReady,
  input  logic [N-1:0]   memRData,
  output logic           stall,
  output logic           branchTaken,
  output logic [N-1:0]   branchTarget,
  output logic [N-1:0]   aluOut,
  output logic [WBW-1:0] wbOut,
  output logic           memError
);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT state, nextState;

  logic [1:0]   opType;
  logic [3:0]   opCode;
  logic [N-1:0] aluResult;
  logic         zero, neg, branchFlag, memWrite, memToReg, regWrite;
  logic [3:0]   rc;
  logic [N-1:0] rd3;

  assign {opType, opCode, aluResult, zero, neg, branchFlag,
          memWrite, memToReg, regWrite, rc, rd3} = bufferIn;

  // opType is carried in the word but has no role in this stage.
  logic unusedOpType;
  assign unusedOpType = ^opType;

  logic         memOp, isLoad, ready, timeoutHit, condMet;
  logic [N-1:0] result;

  assign memOp  = memWrite | memToReg;
  assign isLoad = memToReg & ~memWrite;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CW-1:0] waitCnt;
  logic          errorFlag;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) waitCnt <= '0;
    else                      waitCnt <= waitCnt + CW'(1);
  end

  // The request cycle counts as a wait cycle, so the WAIT count fires one early.
  assign timeoutHit = (state == WAIT) && !memReady && (waitCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)             errorFlag <= 1'b0;
    else if (timeoutHit) errorFlag <= 1'b1;
  end

  assign memError = errorFlag;
`else
  localparam int unusedTimeout = TIMEOUT;
  assign timeoutHit = 1'b0;
  assign memError   = 1'b0;
`endif

  assign ready = memReady | timeoutHit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    memReq    = 1'b0;
    case (state)
      IDLE: begin
        memReq = memOp & en & ~rst;
        if (memReq && !memReady) nextState = WAIT;
      end
      WAIT: begin
        memReq = ~rst;
        if (ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign memWe    = memReq & memWrite;
  assign memAddr  = aluResult;
  assign memWData = rd3;
  assign stall    = memReq & ~ready;

  always_comb begin
    condMet = 1'b0;
    case (opCode)
      4'd0:    condMet = 1'b1;
      4'd1:    condMet = zero;
      4'd2:    condMet = ~zero;
      4'd3:    condMet = neg;
      4'd4:    condMet = ~neg & ~zero;
      default: condMet = 1'b0;
    endcase
  end

  assign branchTaken  = branchFlag & condMet & en & ~stall & ~rst;
  assign branchTarget = aluResult;
  assign aluOut       = aluResult;

  assign result = timeoutHit ? '0 : (isLoad ? memRData : aluResult);

  // Stores never write back; stalled or flushed cycles leave a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbOut <= '0;
    end else if (en) begin
      if (stall || flush) wbOut <= '0;
      else                wbOut <= {regWrite & ~memWrite, rc, result};
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps followed by randomized ops against a rule-level model.
// Honors MEM_STAGE_TIMEOUT_EN for the long-wait step.
module tb_mem_stage;

  localparam int N       = 24;
  localparam int BW      = 16 + 2*N;
  localparam int WBW     = 5 + N;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [3:0]   opCode;
    logic [N-1:0] alu;
    logic         zero;
    logic         neg;
    logic         branchFlag;
    logic         memWrite;
    logic         memToReg;
    logic         regWrite;
    logic [3:0]   rc;
    logic [N-1:0] rd3;
  } opT;

  logic           clk = 1'b0;
  logic           rst, en, flush, memReady;
  logic [BW-1:0]  bufferIn;
  logic [N-1:0]   memRData;
  logic           memReq, memWe, stall, branchTaken, memError;
  logic [N-1:0]   memAddr, memWData, branchTarget, aluOut;
  logic [WBW-1:0] wbOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.N(N), .BW(BW), .WBW(WBW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .bufferIn(bufferIn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memReady(memReady), .memRData(memRData), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .aluOut(aluOut),
    .wbOut(wbOut), .memError(memError)
  );

  task automatic applyStimulus(input opT op);
    bufferIn = {2'($urandom), op.opCode, op.alu, op.zero, op.neg, op.branchFlag,
                op.memWrite, op.memToReg, op.regWrite, op.rc, op.rd3};
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic branchRule(input opT op);
    if (!op.branchFlag) return 1'b0;
    if (op.opCode == 4'd0) return 1'b1;
    if (op.opCode == 4'd1) return op.zero;
    if (op.opCode == 4'd2) return !op.zero;
    if (op.opCode == 4'd3) return op.neg;
    if (op.opCode == 4'd4) return !op.neg && !op.zero;
    return 1'b0;
  endfunction

  function automatic logic [WBW-1:0] wbRule(input opT op, input logic [N-1:0] loadData);
    logic isStore;
    logic isLoad;
    isStore = op.memWrite;
    isLoad  = op.memToReg && !op.memWrite;
    return {op.regWrite && !isStore, op.rc, isLoad ? loadData : op.alu};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    opT op;
    int stallCount;

    rst = 1'b1; en = 1'b1; flush = 1'b0; memReady = 1'b0; memRData = '0;
    op = '0; op.memToReg = 1'b1; op.branchFlag = 1'b1; op.alu = 24'h000055;
    applyStimulus(op);
    #3;
    checkOutput("rstMemReq", memReq, 0);
    checkOutput("rstMemWe", memWe, 0);
    checkOutput("rstStall", stall, 0);
    checkOutput("rstBranch", branchTaken, 0);
    tick;
    checkOutput("rstWbOut", wbOut, 0);
    checkOutput("rstMemError", memError, 0);

    // Plain ALU op writes back aluResult after one edge.
    rst = 1'b0;
    op = '0; op.regWrite = 1'b1; op.rc = 4'd5; op.alu = 24'h00ABCD;
    applyStimulus(op);
    #3;
    checkOutput("aluStall", stall, 0);
    checkOutput("aluMemReq", memReq, 0);
    checkOutput("aluOut", aluOut, 24'h00ABCD);
    tick;
    checkOutput("aluWb", wbOut, {1'b1, 4'd5, 24'h00ABCD});

    // Zero-wait load.
    op = '0; op.memToReg = 1'b1; op.regWrite = 1'b1; op.rc = 4'd3; op.alu = 24'h000010;
    memReady = 1'b1; memRData = 24'h123456;
    applyStimulus(op);
    #3;
    checkOutput("ldMemReq", memReq, 1);
    checkOutput("ldMemWe", memWe, 0);
    checkOutput("ldMemAddr", memAddr, 24'h000010);
    checkOutput("ldStall", stall, 0);
    tick;
    checkOutput("ldWb", wbOut, {1'b1, 4'd3, 24'h123456});

    // Store with three wait cycles.
    op = '0; op.memWrite = 1'b1; op.regWrite = 1'b1; op.rc = 4'd7; op.alu = 24'h000020; op.rd3 = 24'h0000FF;
    memReady = 1'b0; memRData = 24'h0;
    applyStimulus(op);
    for (int k = 0; k < 3; k++) begin
      #3;
      checkOutput("stStall", stall, 1);
      checkOutput("stMemReq", memReq, 1);
      checkOutput("stMemWe", memWe, 1);
      checkOutput("stMemAddr", memAddr, 24'h000020);
      checkOutput("stMemWData", memWData, 24'h0000FF);
      tick;
      checkOutput("stBubble", wbOut, 0);
    end
    memReady = 1'b1;
    #3;
    checkOutput("stDoneStall", stall, 0);
    checkOutput("stDoneMemReq", memReq, 1);
    tick;
    checkOutput("stWb", wbOut, {1'b0, 4'd7, 24'h000020});
    memReady = 1'b0;

    // Branch conditions.
    op = '0; op.branchFlag = 1'b1; op.opCode = 4'd1; op.zero = 1'b1; op.alu = 24'h000400;
    applyStimulus(op); #3;
    checkOutput("brZeroTaken", branchTaken, 1);
    checkOutput("brTarget", branchTarget, 24'h000400);
    op.zero = 1'b0;
    applyStimulus(op); #3;
    checkOutput("brZeroNot", branchTaken, 0);
    op.opCode = 4'd3; op.neg = 1'b1;
    applyStimulus(op); #3;
    checkOutput("brNeg", branchTaken, 1);
    op.opCode = 4'd4; op.neg = 1'b0; op.zero = 1'b0;
    applyStimulus(op); #3;
    checkOutput("brGt", branchTaken, 1);
    op.opCode = 4'd9;
    applyStimulus(op); #3;
    checkOutput("brNever", branchTaken, 0);
    op.opCode = 4'd0; en = 1'b0;
    applyStimulus(op); #3;
    checkOutput("brDisabled", branchTaken, 0);
    en = 1'b1;
    tick;

    // Flush bubble, then en=0 hold.
    op = '0; op.regWrite = 1'b1; op.rc = 4'd2; op.alu = 24'h000777;
    flush = 1'b1;
    applyStimulus(op);
    tick;
    checkOutput("flushWb", wbOut, 0);
    flush = 1'b0;
    tick;
    checkOutput("postFlushWb", wbOut, {1'b1, 4'd2, 24'h000777});
    en = 1'b0; op.alu = 24'h000888;
    applyStimulus(op);
    tick;
    checkOutput("holdWb", wbOut, {1'b1, 4'd2, 24'h000777});
    en = 1'b1;

    // memReady without a request is ignored.
    op = '0; op.regWrite = 1'b1; op.rc = 4'd1; op.alu = 24'h000999;
    memReady = 1'b1; memRData = 24'h00DEAD;
    applyStimulus(op); #3;
    checkOutput("idleReadyStall", stall, 0);
    checkOutput("idleReadyReq", memReq, 0);
    tick;
    checkOutput("idleReadyWb", wbOut, {1'b1, 4'd1, 24'h000999});
    memReady = 1'b0;

    // Reset while waiting abandons the access.
    op = '0; op.memToReg = 1'b1; op.regWrite = 1'b1; op.rc = 4'd4; op.alu = 24'h000030;
    applyStimulus(op); #3;
    checkOutput("rwStall", stall, 1);
    tick; #3;
    checkOutput("rwWaitReq", memReq, 1);
    rst = 1'b1; #2;
    checkOutput("rwRstReq", memReq, 0);
    checkOutput("rwRstStall", stall, 0);
    tick;
    checkOutput("rwRstWb", wbOut, 0);
    rst = 1'b0; en = 1'b0; #2;
    checkOutput("rwIdleAfterRst", memReq, 0);
    en = 1'b1; memReady = 1'b1; memRData = 24'h0ABC12; #2;
    checkOutput("rwFreshReq", memReq, 1);
    checkOutput("rwFreshStall", stall, 0);
    tick;
    checkOutput("rwFreshWb", wbOut, {1'b1, 4'd4, 24'h0ABC12});
    memReady = 1'b0;

    // Load whose memReady never arrives.
    op = '0; op.memToReg = 1'b1; op.regWrite = 1'b1; op.rc = 4'd6; op.alu = 24'h000040;
    applyStimulus(op);
    stallCount = 0;
`ifdef MEM_STAGE_TIMEOUT_EN
    for (int c = 0; c < 200; c++) begin
      #3;
      if (!stall) break;
      stallCount++;
      tick;
    end
    checkOutput("toStallCycles", stallCount, TIMEOUT);
    tick;
    checkOutput("toWb", wbOut, {1'b1, 4'd6, 24'h000000});
    checkOutput("toMemError", memError, 1);
    op = '0;
    applyStimulus(op);
    tick;
    checkOutput("toSticky", memError, 1);
    rst = 1'b1;
    tick;
    checkOutput("toRstClears", memError, 0);
    rst = 1'b0;
`else
    for (int c = 0; c < 110; c++) begin
      #3;
      if (stall && memReq) stallCount++;
      tick;
    end
    checkOutput("longStallCycles", stallCount, 110);
    checkOutput("longNoError", memError, 0);
    memReady = 1'b1; memRData = 24'h654321; #3;
    checkOutput("longDoneStall", stall, 0);
    tick;
    checkOutput("longWb", wbOut, {1'b1, 4'd6, 24'h654321});
    memReady = 1'b0;
`endif

    // Randomized ops with random memory latency.
    for (int i = 0; i < 150; i++) begin
      int            delay;
      logic          flushNow;
      logic          isMem;
      logic [N-1:0]  rdata;
      op.opCode     = 4'($urandom_range(0, 7));
      op.alu        = N'($urandom);
      op.zero       = 1'($urandom);
      op.neg        = 1'($urandom);
      op.branchFlag = 1'($urandom);
      op.memWrite   = 1'($urandom);
      op.memToReg   = 1'($urandom);
      op.regWrite   = 1'($urandom);
      op.rc         = 4'($urandom);
      op.rd3        = N'($urandom);
      isMem    = op.memWrite || op.memToReg;
      delay    = isMem ? $urandom_range(0, 3) : 0;
      flushNow = ($urandom_range(0, 7) == 0);
      rdata    = N'($urandom);
      memReady = 1'b0;
      applyStimulus(op);
      for (int w = 0; w < delay; w++) begin
        memRData = N'($urandom);
        #3;
        checkOutput("rndWaitStall", stall, 1);
        checkOutput("rndWaitBranch", branchTaken, 0);
        tick;
        checkOutput("rndWaitBubble", wbOut, 0);
      end
      memReady = isMem ? 1'b1 : 1'($urandom);
      memRData = rdata;
      flush    = flushNow;
      #3;
      checkOutput("rndStall", stall, 0);
      checkOutput("rndMemReq", memReq, isMem);
      checkOutput("rndMemWe", memWe, isMem && op.memWrite);
      checkOutput("rndMemAddr", memAddr, op.alu);
      checkOutput("rndMemWData", memWData, op.rd3);
      checkOutput("rndBranch", branchTaken, branchRule(op));
      tick;
      checkOutput("rndWb", wbOut, flushNow ? '0 : wbRule(op, rdata));
      flush    = 1'b0;
      memReady = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that consumes the 64-bit EX/MEM word produced by the execute stage. It unpacks the word, performs data-memory loads/stores over a ready-based handshake with variable latency, and resolves conditional branches from the carried flags. It also drives the forwarding value back to execute and registers the MEM/WB word for writeback. Upstream stages are stalled while a memory access is outstanding.

## Interface
Parameters:
- N, 24, datapath width
- BW, 16+2*N, EX/MEM word width (64 at N=24)
- WBW, 5+N, MEM/WB word width
- TIMEOUT, 15, max wait cycles for memReady (used only with the timeout feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  stage enable; low holds MEM/WB and suppresses new requests
- flush  in  1  loads a bubble into MEM/WB on the next edge
- bufferIn  in  BW  EX/MEM word: opType[63:62], opCode[61:58], aluResult[57:34], zero[33], neg[32], branchFlag[31], memWrite[30], memToReg[29], regWrite[28], Rc[27:24], rd3[23:0]
- memReq  out  1  data-memory request
- memWe  out  1  1 = store, 0 = load
- memAddr  out  N  = aluResult
- memWData  out  N  = rd3
- memReady  in  1  memory completes the access this cycle
- memRData  in  N  load data, valid when memReady=1
- stall  out  1  holds IF/ID/EX and EX/MEM
- branchTaken  out  1  redirect fetch
- branchTarget  out  N  = aluResult
- aluOut  out  N  forwarding value = aluResult (combinational)
- wbOut  out  WBW  registered {regWrite, Rc, result}
- memError  out  1  sticky timeout flag (0 when feature compiled out)

## Operation
- memOp = memWrite | memToReg. When both are set, memWrite wins and the access is a store.
- FSM states IDLE and WAIT.
- IDLE:
  - memReq = memOp & en & ~rst.
  - If memReq and memReady: the access completes this cycle; stay in IDLE.
  - If memReq and ~memReady: go to WAIT.
- WAIT:
  - memReq = 1 regardless of en.
  - memAddr, memWData and memWe stay stable, because upstream holds bufferIn under stall.
  - Go to IDLE on memReady.
- stall = memReq & ~memReady.
- Result select: memToReg & ~memWrite selects memRData; otherwise aluResult.
- MEM/WB update, on an edge with en=1:
  - stall=1 or flush=1: load a bubble (all zeros).
  - Otherwise: load {regWrite & ~memWrite, Rc, result}.
  - Stores never write back.
- MEM/WB with en=0: hold.
- Branch condition, evaluated when branchFlag=1, selected by opCode:
  - 0: always
  - 1: zero
  - 2: ~zero
  - 3: neg
  - 4: ~neg & ~zero
  - other: never
- branchTaken = condition & en & ~stall & ~rst.
- rst: state to IDLE, wbOut to 0, memError to 0. memReq, stall and branchTaken are forced 0 during the rst cycle. An access in WAIT is abandoned.

## Timing
- Zero-wait access (memReady in the request cycle): no stall; result is in wbOut after the next edge. Latency 1.
- k-cycle wait: stall is high for k cycles. The result is registered on the edge of the cycle in which memReady=1.
- Reset values: wbOut=0, memReq=0, memWe=0, stall=0, branchTaken=0, memError=0.
- aluOut, branchTarget, memAddr and memWData are combinational from bufferIn, with no register.
- memReady while memReq=0 is ignored.
- flush and stall together: a bubble is loaded; an outstanding access continues.
- en=0 in WAIT: the request is held. Completion is still accepted; the result is lost, so the hazard unit must not drop en mid-access.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A 4-bit-minimum wait counter increments in WAIT.
  - When it reaches TIMEOUT with no memReady, the FSM returns to IDLE and memError sets (sticky until rst).
  - A load completes with result 0; the stall releases the same cycle.
  - The counter clears on entry to WAIT.
- Not defined: no counter; WAIT persists indefinitely; memError tied 0.

## Test plan
- ALU op: regWrite=1, Rc=5, aluResult=0x00ABCD, no memOp -> no stall; next edge wbOut={1,5,0x00ABCD}.
- Zero-wait load: memToReg=1, aluResult=0x000010, memReady=1, memRData=0x123456 in the same cycle -> memReq=1, memWe=0, memAddr=0x10, stall=0; wbOut result=0x123456.
- 3-wait store: memWrite=1, rd3=0x0000FF, memReady low for 3 cycles -> stall high 3 cycles; memReq, memAddr and memWData stable throughout; bubble in wbOut during the stall, regWrite=0 after completion.
- Branches, opCode=1 with zero=1 and then zero=0 -> branchTaken 1 then 0, branchTarget=aluResult. opCode=3 with neg=1 -> taken.
- rst asserted in WAIT -> next cycle state IDLE, stall=0, wbOut=0; a fresh load issues normally afterwards.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT=15: load with memReady never high -> stall exactly 15 cycles, then memError=1 and a load result of 0. Without the macro: stall persists for more than 100 cycles.
